// File: rtl/y86_pkg.sv
// Shared Y86 status/icode definitions for the status-tracking pipeline.
package y86_pkg;
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;

  typedef struct packed {
    stat_e      stat;
    logic [3:0] icode;
  } stage_stat_t;

  localparam stage_stat_t BUBBLE = '{stat: STAT_AOK, icode: I_NOP};
endpackage

// File: rtl/stat_stage_reg.sv
// One {stat, icode} pipeline register; stall has priority over bubble.
module stat_stage_reg
  import y86_pkg::*;
#(
  parameter int ICODE_W = 4,
  parameter int STAT_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stall,
  input  logic               i_bubble,
  input  logic [STAT_W-1:0]  i_stat,
  input  logic [ICODE_W-1:0] i_icode,
  output logic [STAT_W-1:0]  o_stat,
  output logic [ICODE_W-1:0] o_icode
);
  localparam logic [STAT_W-1:0]  BUB_STAT  = STAT_W'(STAT_AOK);
  localparam logic [ICODE_W-1:0] BUB_ICODE = ICODE_W'(I_NOP);

  logic [STAT_W-1:0]  r_stat;
  logic [ICODE_W-1:0] r_icode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat  <= BUB_STAT;
      r_icode <= BUB_ICODE;
    end else if (i_stall) begin
      r_stat  <= r_stat;
      r_icode <= r_icode;
    end else if (i_bubble) begin
      r_stat  <= BUB_STAT;
      r_icode <= BUB_ICODE;
    end else begin
      r_stat  <= i_stat;
      r_icode <= i_icode;
    end
  end

  assign o_stat  = r_stat;
  assign o_icode = r_icode;
endmodule

// File: rtl/stat_pipe.sv
// Y86 status pipeline D/E/M/W with exception controls and monitor outputs.
// Optional retired-instruction counter: define STAT_PIPE_RETIRE_CNT_EN.
module stat_pipe
  import y86_pkg::*;
#(
  parameter int ICODE_W = 4,
  parameter int STAT_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ICODE_W-1:0] f_icode,
  input  logic               f_instr_valid,
  input  logic               f_imem_error,
  input  logic               m_dmem_error,
  input  logic               d_stall,
  input  logic               d_bubble,
  input  logic               e_bubble,
  output logic               memory_error,
  output logic               instr_valid,
  output logic               halt,
  output logic [ICODE_W-1:0] icode,
  output logic               m_bubble,
  output logic               cc_inhibit,
  output logic               f_freeze,
  output logic               w_stall
`ifdef STAT_PIPE_RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_cnt
`endif
);
  localparam int STAGES = 4;
  localparam int SD = 0, SE = 1, SM = 2, SW = 3;
  localparam logic [STAT_W-1:0]  S_AOK = STAT_W'(STAT_AOK);
  localparam logic [STAT_W-1:0]  S_HLT = STAT_W'(STAT_HLT);
  localparam logic [STAT_W-1:0]  S_ADR = STAT_W'(STAT_ADR);
  localparam logic [STAT_W-1:0]  S_INS = STAT_W'(STAT_INS);
  localparam logic [ICODE_W-1:0] C_HALT = ICODE_W'(I_HALT);
  localparam logic [ICODE_W-1:0] C_NOP  = ICODE_W'(I_NOP);

  logic [STAT_W-1:0]                w_f_stat;
  logic [STAT_W-1:0]                w_m_stat;
  logic [STAGES-1:0][STAT_W-1:0]    w_in_stat;
  logic [STAGES-1:0][ICODE_W-1:0]   w_in_icode;
  logic [STAGES-1:0][STAT_W-1:0]    w_q_stat;
  logic [STAGES-1:0][ICODE_W-1:0]   w_q_icode;
  logic [STAGES-1:0]                w_stall_v;
  logic [STAGES-1:0]                w_bubble_v;

  always_comb begin
    if (f_imem_error)        w_f_stat = S_ADR;
    else if (!f_instr_valid) w_f_stat = S_INS;
    else if (f_icode == C_HALT) w_f_stat = S_HLT;
    else                     w_f_stat = S_AOK;
  end

  // A data-memory fault overrides whatever status the M instruction carried.
  assign w_m_stat = m_dmem_error ? S_ADR : w_q_stat[SM];

  assign w_in_stat  = {w_m_stat, w_q_stat[SE], w_q_stat[SD], w_f_stat};
  assign w_in_icode = {w_q_icode[SM], w_q_icode[SE], w_q_icode[SD], f_icode};
  assign w_stall_v  = {w_stall, 1'b0, 1'b0, d_stall};
  assign w_bubble_v = {1'b0, m_bubble, e_bubble, d_bubble};

  for (genvar g = 0; g < STAGES; g++) begin : g_stg
    stat_stage_reg #(.ICODE_W(ICODE_W), .STAT_W(STAT_W)) u_reg (
      .clk      (clk),
      .rst      (rst),
      .i_stall  (w_stall_v[g]),
      .i_bubble (w_bubble_v[g]),
      .i_stat   (w_in_stat[g]),
      .i_icode  (w_in_icode[g]),
      .o_stat   (w_q_stat[g]),
      .o_icode  (w_q_icode[g])
    );
  end

  assign w_stall    = (w_q_stat[SW] != S_AOK);
  assign m_bubble   = (w_m_stat != S_AOK) || w_stall;
  assign cc_inhibit = m_bubble;

  always_comb begin
    f_freeze = (w_f_stat != S_AOK);
    for (int i = 0; i < STAGES; i++)
      if (w_q_stat[i] != S_AOK) f_freeze = 1'b1;
  end

  assign memory_error = (w_q_stat[SW] == S_ADR);
  assign instr_valid  = (w_q_stat[SW] != S_INS);
  assign halt         = (w_q_stat[SW] == S_HLT);
  assign icode        = w_q_icode[SW];

`ifdef STAT_PIPE_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_retire_cnt <= '0;
    else if (!w_stall && (w_m_stat == S_AOK) && (w_q_icode[SM] != C_NOP))
      r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign retire_cnt = r_retire_cnt;
`endif
endmodule

// File: doc/stat_pipe.md
# stat_pipe

- Tracks Y86 instruction status codes alongside the pipeline from fetch through write-back.
- Merges fetch-time and data-memory exceptions.
- Drives the simulation monitor's `memory_error`, `instr_valid`, `halt` and `icode` inputs from the write-back (retiring) instruction.
- Produces the exception-driven pipeline controls: M-stage bubble, condition-code inhibit, fetch freeze, W freeze.
- Sits between the fetch/hazard-control logic (upstream) and the processor status monitor (downstream).

## Interface

Parameters:
- `ICODE_W`, 4, icode width
- `STAT_W`, 3, status-code width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `f_icode`  in  ICODE_W  icode of the instruction being fetched
- `f_instr_valid`  in  1  fetch decoded a legal icode/ifun
- `f_imem_error`  in  1  instruction-memory address out of range
- `m_dmem_error`  in  1  data-memory access error for the instruction in M
- `d_stall`  in  1  hold D register (from hazard unit)
- `d_bubble`  in  1  load NOP into D
- `e_bubble`  in  1  load NOP into E
- `memory_error`  out  1  W instruction has status ADR
- `instr_valid`  out  1  W instruction status is not INS
- `halt`  out  1  W instruction has status HLT
- `icode`  out  ICODE_W  icode of the W instruction
- `m_bubble`  out  1  M stage must be bubbled
- `cc_inhibit`  out  1  block condition-code update
- `f_freeze`  out  1  stop PC advance
- `w_stall`  out  1  W register frozen

## Operation

- Status codes: AOK=1, HLT=2, ADR=3, INS=4. Bubble = {stat AOK, icode NOP=1}.
- Fetch status, priority order:
  - `f_imem_error` → ADR
  - else `!f_instr_valid` → INS
  - else `f_icode==0` → HLT
  - else AOK
- Stage registers D, E, M, W each hold {stat, icode}.
- D update:
  - `d_stall` → hold
  - `d_bubble` → bubble
  - else load fetch status
  - `d_stall` beats `d_bubble` if both are asserted.
- E update: `e_bubble` → bubble, else load D.
- M update: `m_bubble` → bubble, else load E.
- M-stage status `m_stat` = ADR if `m_dmem_error`, else the M register's stat.
- W update: `w_stall` → hold, else load {`m_stat`, M icode}.
- Control outputs (combinational):
  - `w_stall` = W stat ≠ AOK
  - `m_bubble` = `m_stat` ≠ AOK or W stat ≠ AOK
  - `cc_inhibit` = same as `m_bubble`
  - `f_freeze` = any of D/E/M/W stat ≠ AOK, or fetch status ≠ AOK
- Monitor outputs (combinational from W only):
  - `memory_error` = (W stat == ADR)
  - `instr_valid` = (W stat ≠ INS)
  - `halt` = (W stat == HLT)
  - `icode` = W icode
- Once W holds a non-AOK status it is permanent until `rst`.

## Timing

- Reset state: all four registers = bubble. Resulting outputs:
  - `memory_error`=0, `instr_valid`=1, `halt`=0, `icode`=4'h1
  - `m_bubble`=0, `cc_inhibit`=0, `f_freeze`=0, `w_stall`=0
- Reset icode is NOP, never 0, so the monitor does not halt out of reset.
- Latency, fetch to monitor visibility: 4 rising edges (D, E, M, W); shifted by each `d_stall` cycle.
- Dmem error to visibility: `m_dmem_error` in cycle n → W/`memory_error` valid after edge n.
- Simultaneous `m_dmem_error` and M stat INS/HLT: ADR wins.
- `rst` mid-operation: all registers are cleared asynchronously; outputs reach reset values without waiting for a clock edge.
- Inputs are sampled only at the rising edge; no combinational path from inputs to monitor outputs.

## Configuration

- Macro: `STAT_PIPE_RETIRE_CNT_EN`.
- Defined:
  - Adds output `retire_cnt`, 32 bits, reset 0.
  - Increments on each edge where W loads a non-bubble AOK instruction (icode ≠ NOP) and `w_stall`=0.
  - Wraps modulo 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure

- Shared package `y86_pkg`: stat enum (AOK/HLT/ADR/INS), icode constants (HALT=0, NOP=1), `stage_stat_t` struct {stat, icode}.
- One natural sub-module, `stat_stage_reg`: a {stat, icode} register with async reset, stall and bubble inputs. Instantiated four times.
- Fetch-status priority encoder and control equations stay in the top.

## Test plan

- Reset, then idle clocks with f_icode=NOP and valid fetch → `icode`=1, `halt`=0, `instr_valid`=1, `memory_error`=0 on all cycles.
- f_icode=0 fetched at cycle 0 → `f_freeze`=1 that cycle; `halt`=1 and `icode`=0 after edge 4; `w_stall`=1 thereafter.
- `f_instr_valid`=0 together with `f_imem_error`=1 → after 4 edges `memory_error`=1 and `instr_valid`=1 (ADR priority).
- `m_dmem_error` pulsed while M holds OPq (icode 6) → next edge: `memory_error`=1, `icode`=6; `m_bubble`=1 and `cc_inhibit`=1 from that cycle on.
- `d_stall` held for 2 cycles during a HLT fetch → `halt` appears after 6 edges; assert `d_stall`+`d_bubble` together → D holds its value.
- `rst` asserted mid-halt → outputs return to reset values asynchronously; with `STAT_PIPE_RETIRE_CNT_EN`, `retire_cnt`=3 after three retired OPq instructions.
